regs_writeback: RTL

//   Write-side front end of the register file. Accepts results from two producers
//   (ALU, load unit) over valid/ready handshakes. Queues them in order and drives
//   the register file write port, one write per cycle.

---
 rtl/regs_writeback.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regs_writeback.sv
// Register file write-side front end: two-producer arbiter, in-order write queue,
// registered write port and per-register pending-write scoreboard.
module regs_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_a_valid,
    output logic                          o_a_ready,
    input  logic [INDEX_WIDTH-1:0]        i_a_addr,
    input  logic [DATA_WIDTH-1:0]         i_a_data,
    input  logic                          i_b_valid,
    output logic                          o_b_ready,
    input  logic [INDEX_WIDTH-1:0]        i_b_addr,
    input  logic [DATA_WIDTH-1:0]         i_b_data,
    input  logic                          i_hold,
    input  logic                          i_rsv_we,
    input  logic [INDEX_WIDTH-1:0]        i_rsv_addr,
    output logic                          o_we,
    output logic [INDEX_WIDTH-1:0]        o_waddr,
    output logic [DATA_WIDTH-1:0]         o_wdata,
    output logic [(1<<INDEX_WIDTH)-1:0]   o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int NREGS = 1 << INDEX_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INDEX_WIDTH-1:0] r_qAddr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  r_qData [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_rdPtr;
    logic [PTR_W-1:0]       r_wrPtr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ptrB;
    logic                   r_we;
    logic [INDEX_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [NREGS-1:0]       r_busy;

    logic                   w_deq;
    logic                   w_space;
    logic                   w_grantA;
    logic                   w_grantB;
    logic                   w_accA;
    logic                   w_accB;
    logic                   w_enq;
    logic [INDEX_WIDTH-1:0] w_accAddr;
    logic [DATA_WIDTH-1:0]  w_accData;
    logic [NREGS-1:0]       w_busyNext;

    assign w_deq     = (r_count != '0) && !i_hold;
    assign w_space   = (r_count < CNT_W'(FIFO_DEPTH)) || w_deq;
    assign w_grantA  = i_a_valid && (!i_b_valid || !r_ptrB);
    assign w_grantB  = i_b_valid && (!i_a_valid || r_ptrB);
    assign o_a_ready = w_space && w_grantA;
    assign o_b_ready = w_space && w_grantB;
    assign w_accA    = i_a_valid && o_a_ready;
    assign w_accB    = i_b_valid && o_b_ready;
    assign w_accAddr = w_accA ? i_a_addr : i_b_addr;
    assign w_accData = w_accA ? i_a_data : i_b_data;
    // Writes to x0 complete the handshake but never occupy a queue slot.
    assign w_enq     = (w_accA || w_accB) && (w_accAddr != '0);

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_busy  = r_busy;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_qAddr[r_wrPtr] <= w_accAddr;
            r_qData[r_wrPtr] <= w_accData;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_ptrB  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_deq) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_waddr <= r_qAddr[r_rdPtr];
                r_wdata <= r_qData[r_rdPtr];
            end
            r_we    <= w_deq;
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            // Round-robin only advances on contested grants.
            if (i_a_valid && i_b_valid && (w_accA || w_accB)) begin
                r_ptrB <= ~r_ptrB;
            end
        end
    end

    // A reservation landing on the same edge as the retiring write keeps the bit set.
    always_comb begin
        w_busyNext = r_busy;
        if (r_we) begin
            w_busyNext[r_waddr] = 1'b0;
        end
        if (i_rsv_we && (i_rsv_addr != '0)) begin
            w_busyNext[i_rsv_addr] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

endmodule
